// File: rtl/uart_rx_if.sv
// Byte-level signal bundle of the UART receiver: serial line in, byte and strobes out.
// The master side drives the line; the slave side is the receiver.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data_out;
   logic       ready_out;
   logic       frame_err;
   logic       busy;

   modport master (output rx, input data_out, ready_out, frame_err, busy);
   modport slave  (input rx, output data_out, ready_out, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM, and registered
// single-cycle byte/frame-error strobes. A held-low line parks in BREAK.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);
   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             rx_s1_q, rx_s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;

   // State, datapath and synchronizer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         ready_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_s1_q   <= bus.rx;
         rx_s2_q   <= rx_s1_q;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic; the strobes default low so each is set for exactly one cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      ready_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s2_q) begin
               state_d = START;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               if (!rx_s2_q) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               shift_d = {rx_s2_q, shift_q[7:1]};
               cnt_d   = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         BREAK: begin
            if (rx_s2_q) begin
               state_d = IDLE;
            end else begin
               state_d = BREAK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.data_out  = data_q;
   assign bus.ready_out = ready_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of framed bytes at 16 clocks/bit, hand-written
// back-to-back, glitch and mid-frame-reset sequences, and one frame at 868 clocks/bit.
module tb_uart_rx;
   localparam int CPB_A = 16;
   localparam int CPB_B = 868;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   t0 = 0;
   int   both_cnt = 0;

   int         rdy_cyc_q[$];
   logic [7:0] rdy_dat_q[$];
   int         fe_cyc_q[$];
   int         rdyb_cyc_q[$];
   logic       busy_log[0:399];

   uart_rx_if bus_a ();
   uart_rx_if bus_b ();

   uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe and busy monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus_a.ready_out) begin
         rdy_cyc_q.push_back(cyc);
         rdy_dat_q.push_back(bus_a.data_out);
      end
      if (bus_a.frame_err) fe_cyc_q.push_back(cyc);
      if (bus_a.ready_out && bus_a.frame_err) both_cnt <= both_cnt + 1;
      if (bus_b.ready_out) rdyb_cyc_q.push_back(cyc);
      if ((cyc - t0) >= 0 && (cyc - t0) < 400) busy_log[cyc - t0] <= bus_a.busy;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive_bits(input bit sel, input logic v, input int n);
      if (sel) bus_b.rx = v;
      else     bus_a.rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_b, input int cpb);
      drive_bits(sel, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bits(sel, b[i], cpb);
      drive_bits(sel, stop_b, cpb);
   endtask

   task automatic clear_q();
      rdy_cyc_q.delete();
      rdy_dat_q.delete();
      fe_cyc_q.delete();
      rdyb_cyc_q.delete();
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      int         hold_low;
      logic [7:0] exp_data;
      int         exp_ready;
      int         exp_ferr;
      logic       exp_busy_end;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int first;
      vecs[0] = '{8'hA5, 1'b1, 0,   8'hA5, 1, 0, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 0,   8'h00, 1, 0, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 0,   8'hFF, 1, 0, 1'b0};
      vecs[3] = '{8'h3C, 1'b0, 100, 8'hFF, 0, 1, 1'b1};
      vecs[4] = '{8'h6B, 1'b1, 0,   8'h6B, 1, 0, 1'b0};

      bus_a.rx = 1'b1;
      bus_b.rx = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset data_out", bus_a.data_out, 8'h00);
      check("reset ready_out", bus_a.ready_out, 1'b0);
      check("reset frame_err", bus_a.frame_err, 1'b0);
      check("reset busy", bus_a.busy, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Table of single frames; strobe lands on the cycle after E154 (offset 155 from drive)
      for (int v = 0; v < 5; v++) begin
         clear_q();
         t0 = cyc;
         send_frame(1'b0, vecs[v].data, vecs[v].stop_b, CPB_A);
         if (vecs[v].hold_low > 0) drive_bits(1'b0, 1'b0, vecs[v].hold_low);
         if (vecs[v].hold_low > 0) check($sformatf("v%0d busy in break", v), bus_a.busy, 1'b1);
         drive_bits(1'b0, 1'b1, 20);
         check($sformatf("v%0d ready count", v), rdy_cyc_q.size(), vecs[v].exp_ready);
         check($sformatf("v%0d ferr count", v), fe_cyc_q.size(), vecs[v].exp_ferr);
         if (vecs[v].exp_ready > 0)
            check($sformatf("v%0d ready cycle", v), (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - t0 : -1, 155);
         else
            check($sformatf("v%0d ferr cycle", v), (fe_cyc_q.size() > 0) ? fe_cyc_q[0] - t0 : -1, 155);
         check($sformatf("v%0d data_out", v), bus_a.data_out, vecs[v].exp_data);
         check($sformatf("v%0d busy after E1", v), busy_log[2], 1'b0);
         check($sformatf("v%0d busy after E2", v), busy_log[3], 1'b1);
         check($sformatf("v%0d busy after E153", v), busy_log[154], 1'b1);
         check($sformatf("v%0d busy after E154", v), busy_log[155], vecs[v].exp_busy_end);
         check($sformatf("v%0d busy idle", v), bus_a.busy, 1'b0);
      end

      // Back-to-back frames with no idle gap
      clear_q();
      t0 = cyc;
      for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b1, CPB_A);
      drive_bits(1'b0, 1'b1, 20);
      check("b2b ready count", rdy_cyc_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("b2b cycle %0d", i), (rdy_cyc_q.size() > i) ? rdy_cyc_q[i] - t0 : -1, 155 + 160 * i);
         check($sformatf("b2b data %0d", i), (rdy_dat_q.size() > i) ? rdy_dat_q[i] : 8'hxx, 8'(i + 1));
      end

      // Glitch shorter than half a bit, then a valid 0x55
      clear_q();
      drive_bits(1'b0, 1'b0, 5);
      drive_bits(1'b0, 1'b1, 30);
      check("glitch strobes", rdy_cyc_q.size() + fe_cyc_q.size(), 0);
      check("glitch busy", bus_a.busy, 1'b0);
      check("glitch data kept", bus_a.data_out, 8'h04);
      t0 = cyc;
      send_frame(1'b0, 8'h55, 1'b1, CPB_A);
      drive_bits(1'b0, 1'b1, 20);
      check("post-glitch ready count", rdy_cyc_q.size(), 1);
      check("post-glitch ready cycle", (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - t0 : -1, 155);
      check("post-glitch data", bus_a.data_out, 8'h55);

      // Reset in the middle of bit 4 of 0xFF
      clear_q();
      drive_bits(1'b0, 1'b0, CPB_A);
      for (int i = 0; i < 4; i++) drive_bits(1'b0, 1'b1, CPB_A);
      drive_bits(1'b0, 1'b1, CPB_A / 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset data_out", bus_a.data_out, 8'h00);
      check("midreset busy", bus_a.busy, 1'b0);
      drive_bits(1'b0, 1'b1, 100);
      check("midreset no strobe", rdy_cyc_q.size() + fe_cyc_q.size(), 0);
      t0 = cyc;
      send_frame(1'b0, 8'h81, 1'b1, CPB_A);
      drive_bits(1'b0, 1'b1, 20);
      check("post-reset ready count", rdy_cyc_q.size(), 1);
      check("post-reset data", bus_a.data_out, 8'h81);

      // Real baud rate: strobe on the cycle after E(2+434+7812)
      clear_q();
      t0 = cyc;
      send_frame(1'b1, 8'h7E, 1'b1, CPB_B);
      drive_bits(1'b1, 1'b1, 10);
      check("baud ready count", rdyb_cyc_q.size(), 1);
      first = (rdyb_cyc_q.size() > 0) ? rdyb_cyc_q[0] - t0 : -1;
      check("baud ready cycle", first, 1 + 2 + 434 + 7812);
      check("baud data", bus_b.data_out, 8'h7E);

      check("strobes never coincide", both_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
